pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central pipeline control for the 5-stage MIPS core. It merges load-use hazard detection, taken-branch flush, instruction-memory wait and a multi-cycle data-memory handshake into one prioritised set of per-stage write/flush enables. It sits beside the hazard/forwarding logic and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register controls. It also keeps a data-memory timeout watchdog and saturating stall/flush performance counters.

## Interface
Parameters:
- TIMEOUT, 64, max cycles in DMEM_WAIT before fault (≥2)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Register_Rt  in  5  load destination
- IF_ID_Register_Rs  in  5  ID source 1
- IF_ID_Register_Rt  in  5  ID source 2
- EX_branch_taken  in  1  taken branch/jump resolved in EX
- MEM_mem_access  in  1  load/store in MEM
- dmem_ready  in  1  data memory completes access this cycle
- imem_ready  in  1  instruction fetch valid this cycle
- dmem_req  out  1  data memory request, held until ready
- PC_write  out  1  1 = PC updates
- IF_ID_Write  out  1  1 = IF/ID loads
- IF_ID_Flush  out  1  1 = IF/ID loads bubble
- ID_EX_Flush  out  1  1 = ID/EX loads bubble (control zeroed)
- EX_MEM_Write  out  1  1 = EX/MEM and ID/EX load
- MEM_WB_Bubble  out  1  1 = MEM/WB loads bubble
- mem_error  out  1  sticky timeout fault
- stall_cycles  out  CNT_W  saturating count of cycles with PC_write=0
- flush_count  out  CNT_W  saturating count of branch flushes

## Operation
- FSM states: RUN, DMEM_WAIT, HALT. Reset → RUN.
- Control outputs are Mealy (state + current inputs). Counters, state, watchdog and mem_error are registered.
- load_use = ID_EX_MemRead && ID_EX_Register_Rt != 0 && (Rt == IF_ID_Register_Rs || Rt == IF_ID_Register_Rt).
- Default (no event): PC_write=1, IF_ID_Write=1, EX_MEM_Write=1, all flush/bubble=0, dmem_req=0.
- RUN, conditions in priority order:
  1. MEM_mem_access: dmem_req=1.
     - If dmem_ready: default enables, stay RUN (zero-wait access).
     - Else freeze: PC_write=0, IF_ID_Write=0, EX_MEM_Write=0, MEM_WB_Bubble=1; next DMEM_WAIT, watchdog=1.
  2. EX_branch_taken: PC_write=1, IF_ID_Flush=1, ID_EX_Flush=1; flush_count++.
  3. load_use: PC_write=0, IF_ID_Write=0, ID_EX_Flush=1; IF_ID_Flush=0 regardless of imem_ready.
  4. !imem_ready: PC_write=0, IF_ID_Flush=1; downstream advances.
- DMEM_WAIT:
  - dmem_req=1.
  - If dmem_ready: apply RUN rules 2–4 this cycle, next RUN.
  - Else freeze as above and watchdog++; when watchdog reaches TIMEOUT, next HALT and set mem_error.
- HALT: PC_write=IF_ID_Write=EX_MEM_Write=0, IF_ID_Flush=ID_EX_Flush=MEM_WB_Bubble=1, dmem_req=0. Leaves only on reset.
- Counters saturate at all-ones and do not increment in HALT or during reset.

## Timing
- While reset=1: PC_write=0, IF_ID_Write=0, EX_MEM_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, MEM_WB_Bubble=1, dmem_req=0. On the next edge: state=RUN, watchdog=0, mem_error=0, counters=0.
- Reset mid-DMEM_WAIT or HALT aborts immediately; dmem_req drops in the same cycle reset is seen.
- Load-use costs exactly 1 stall cycle; the next cycle ID_EX_MemRead is 0 from the bubble.
- A taken branch costs 2 squashed instructions; flush_count increments once per cycle EX_branch_taken is acted on.
- A branch held in EX during DMEM_WAIT is acted on in the release cycle only, with one flush_count increment.
- dmem_req is stable from first assertion until the cycle dmem_ready=1 is sampled.
- Watchdog: fault when TIMEOUT consecutive freeze cycles are seen without ready. mem_error rises one edge after the last wait cycle.

## Structure
- Package pipe_ctrl_pkg: state enum (RUN, DMEM_WAIT, HALT), default TIMEOUT, CNT_W, REG_ZERO=5'd0.
- Sub-module sat_counter (param width; inputs inc, clr; output count), instantiated twice.
- Watchdog width is $clog2(TIMEOUT+1).

## Test plan
- Load r2 in EX (ID_EX_Register_Rt=2), IF_ID_Register_Rs=2 → one cycle PC_write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cycles=1.
- ID_EX_Register_Rt=0 with IF_ID_Register_Rs=0, MemRead=1 → no stall, all defaults.
- EX_branch_taken=1 together with a load_use match → branch wins: IF_ID_Flush=ID_EX_Flush=1, PC_write=1; flush_count=1.
- MEM_mem_access=1, dmem_ready low 3 cycles then high → dmem_req held 4 cycles, 3 freeze cycles, release on the 4th; stall_cycles=3; state returns to RUN.
- TIMEOUT=4, dmem_ready never asserted → HALT after 4 wait cycles, mem_error=1, outputs at HALT values. Then reset=1 → all clear after one edge.
- load_use with imem_ready=0 → IF_ID_Flush stays 0. imem_ready=0 alone → PC_write=0, IF_ID_Flush=1, EX_MEM_Write=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Holds the controller state encoding, default sizing parameters and the
// load-use hazard helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        HALT      = 2'd2
    } state_t;

    localparam int          DEFAULT_TIMEOUT = 64;
    localparam int          DEFAULT_CNT_W   = 32;
    localparam logic [4:0]  REG_ZERO        = 5'd0;

    // r0 is hard-wired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous clear (wins over inc)
//   inc   - count one event this cycle
//   count - current value, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline control for the 5-stage core.
// Merges data-memory wait, taken-branch flush, load-use stall and
// instruction-fetch wait into one prioritised set of per-stage enables,
// and keeps a data-memory timeout watchdog plus stall/flush counters.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   ID_EX_MemRead/Register_Rt  - load in EX and its destination
//   IF_ID_Register_Rs/Rt       - source registers of the instruction in ID
//   EX_branch_taken            - taken branch/jump resolved in EX
//   MEM_mem_access             - load/store in MEM
//   dmem_ready, imem_ready     - memory completion / fetch valid
//   dmem_req                   - data memory request, held until ready
//   PC_write .. MEM_WB_Bubble  - per-stage write / flush / bubble controls
//   mem_error                  - sticky data-memory timeout fault
//   stall_cycles, flush_count  - saturating performance counters
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Register_Rt,
    input  logic [4:0]       IF_ID_Register_Rs,
    input  logic [4:0]       IF_ID_Register_Rt,
    input  logic             EX_branch_taken,
    input  logic             MEM_mem_access,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             PC_write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [WD_W-1:0] watchdog;
    logic            load_use;
    logic            freeze;
    logic            branch_act;

    // Front-end rules (branch > load-use > fetch wait), shared by RUN and
    // the DMEM_WAIT release cycle.
    logic fe_pc_write, fe_if_id_write, fe_if_id_flush, fe_id_ex_flush, fe_branch;

    assign load_use = load_use_hit(ID_EX_MemRead, ID_EX_Register_Rt,
                                   IF_ID_Register_Rs, IF_ID_Register_Rt);

    always_comb begin
        fe_pc_write    = 1'b1;
        fe_if_id_write = 1'b1;
        fe_if_id_flush = 1'b0;
        fe_id_ex_flush = 1'b0;
        fe_branch      = 1'b0;
        if (EX_branch_taken) begin
            fe_if_id_flush = 1'b1;
            fe_id_ex_flush = 1'b1;
            fe_branch      = 1'b1;
        end else if (load_use) begin
            // The stalled instruction must stay in IF/ID, so no flush even
            // when the fetch is not valid.
            fe_pc_write    = 1'b0;
            fe_if_id_write = 1'b0;
            fe_id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            fe_pc_write    = 1'b0;
            fe_if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        dmem_req      = 1'b0;
        PC_write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Write  = 1'b1;
        MEM_WB_Bubble = 1'b0;
        freeze        = 1'b0;
        branch_act    = 1'b0;
        if (reset) begin
            PC_write      = 1'b0;
            IF_ID_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            IF_ID_Flush   = 1'b1;
            ID_EX_Flush   = 1'b1;
            MEM_WB_Bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (MEM_mem_access) begin
                        dmem_req = 1'b1;
                        if (!dmem_ready) begin
                            freeze    = 1'b1;
                            state_nxt = DMEM_WAIT;
                        end
                    end else begin
                        PC_write    = fe_pc_write;
                        IF_ID_Write = fe_if_id_write;
                        IF_ID_Flush = fe_if_id_flush;
                        ID_EX_Flush = fe_id_ex_flush;
                        branch_act  = fe_branch;
                    end
                end
                DMEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        PC_write    = fe_pc_write;
                        IF_ID_Write = fe_if_id_write;
                        IF_ID_Flush = fe_if_id_flush;
                        ID_EX_Flush = fe_id_ex_flush;
                        branch_act  = fe_branch;
                        state_nxt   = RUN;
                    end else begin
                        freeze = 1'b1;
                        // This cycle is the TIMEOUT-th consecutive freeze.
                        if (watchdog >= WD_LAST) begin
                            state_nxt = HALT;
                        end
                    end
                end
                HALT: begin
                    PC_write      = 1'b0;
                    IF_ID_Write   = 1'b0;
                    EX_MEM_Write  = 1'b0;
                    IF_ID_Flush   = 1'b1;
                    ID_EX_Flush   = 1'b1;
                    MEM_WB_Bubble = 1'b1;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
            if (freeze) begin
                PC_write      = 1'b0;
                IF_ID_Write   = 1'b0;
                EX_MEM_Write  = 1'b0;
                MEM_WB_Bubble = 1'b1;
            end
        end
    end

    // State, watchdog and fault register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            watchdog  <= '0;
            mem_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (freeze) begin
                watchdog <= (state == RUN) ? WD_W'(1) : watchdog + WD_W'(1);
            end else begin
                watchdog <= '0;
            end
            if ((state == DMEM_WAIT) && (state_nxt == HALT)) begin
                mem_error <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (!reset && (state != HALT) && !PC_write),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (branch_act),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    // Output vector order: {dmem_req, PC_write, IF_ID_Write, IF_ID_Flush,
    //                       ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble}
    localparam logic [6:0] O_DEF = 7'b0110010;
    localparam logic [6:0] O_FRZ = 7'b1000001;
    localparam logic [6:0] O_MOK = 7'b1110010;
    localparam logic [6:0] O_BR  = 7'b0111110;
    localparam logic [6:0] O_LU  = 7'b0000110;
    localparam logic [6:0] O_IF  = 7'b0011010;
    localparam logic [6:0] O_HLT = 7'b0001101;
    localparam logic [6:0] O_REQ = 7'b1000000;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [4:0] ext;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       ma;
        logic       dr;
        logic       ir;
    } in_t;

    typedef struct {
        string      name;
        in_t        i;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t cur;
    logic dmem_req, PC_write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic EX_MEM_Write, MEM_WB_Bubble, mem_error;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [6:0] o;

    assign o = {dmem_req, PC_write, IF_ID_Write, IF_ID_Flush,
                ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble};

    pipeline_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (cur.rst),
        .ID_EX_MemRead     (cur.mr),
        .ID_EX_Register_Rt (cur.ext),
        .IF_ID_Register_Rs (cur.rs),
        .IF_ID_Register_Rt (cur.rt),
        .EX_branch_taken   (cur.br),
        .MEM_mem_access    (cur.ma),
        .dmem_ready        (cur.dr),
        .imem_ready        (cur.ir),
        .dmem_req          (dmem_req),
        .PC_write          (PC_write),
        .IF_ID_Write       (IF_ID_Write),
        .IF_ID_Flush       (IF_ID_Flush),
        .ID_EX_Flush       (ID_EX_Flush),
        .EX_MEM_Write      (EX_MEM_Write),
        .MEM_WB_Bubble     (MEM_WB_Bubble),
        .mem_error         (mem_error),
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic in_t mk(input logic rst, input logic mr, input int ext,
                               input int rs, input int rt, input logic br,
                               input logic ma, input logic dr, input logic ir);
        in_t x;
        x.rst = rst; x.mr = mr;
        x.ext = 5'(ext); x.rs = 5'(rs); x.rt = 5'(rt);
        x.br = br; x.ma = ma; x.dr = dr; x.ir = ir;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check the Mealy outputs mid-cycle, then
    // advance past the clock edge.
    task automatic step(input string nm, input in_t x, input logic [6:0] exp);
        cur = x;
        #3;
        chk(nm, 32'(o), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Events: 0 none, 1 zero-wait mem, 2 freeze, 3 branch, 4 load-use,
    //         5 fetch wait, 6 halted, 7 reset
    bit m_wait, m_halt, m_err;
    int m_frz, m_stall, m_flush;

    function automatic int classify(input in_t x);
        bit lu;
        lu = x.mr && (x.ext != 0) && ((x.ext == x.rs) || (x.ext == x.rt));
        if (x.rst) return 7;
        if (m_halt) return 6;
        if (!m_wait && x.ma) return x.dr ? 1 : 2;
        if (m_wait && !x.dr) return 2;
        if (x.br) return 3;
        if (lu) return 4;
        if (!x.ir) return 5;
        return 0;
    endfunction

    function automatic logic [6:0] expect_out(input int ev);
        logic [6:0] r;
        case (ev)
            1: r = O_MOK;
            2: r = O_FRZ;
            3: r = O_BR;
            4: r = O_LU;
            5: r = O_IF;
            6: r = O_HLT;
            7: r = O_HLT;
            default: r = O_DEF;
        endcase
        if (m_wait && ev inside {0, 3, 4, 5}) r = r | O_REQ;
        return r;
    endfunction

    task automatic commit(input int ev, input logic [6:0] e);
        if (ev == 7) begin
            m_wait = 0; m_halt = 0; m_err = 0; m_frz = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e[5] && ev != 6 && m_stall < CMAX) m_stall++;
            if (ev == 3 && m_flush < CMAX) m_flush++;
            if (ev == 2) begin
                m_frz = m_wait ? m_frz + 1 : 1;
                m_wait = 1;
                if (m_frz >= TO) begin
                    m_halt = 1; m_err = 1; m_wait = 0;
                end
            end else if (ev != 6) begin
                m_wait = 0;
                m_frz = 0;
            end
        end
    endtask

    vec_t vecs[$];
    in_t  rst_in, idle;

    initial begin
        rst_in = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cur = rst_in;

        vecs.push_back('{"idle",          idle,                               O_DEF});
        vecs.push_back('{"lu_rs",         mk(0, 1, 2, 2, 5, 0, 0, 1, 1),      O_LU});
        vecs.push_back('{"lu_rt",         mk(0, 1, 7, 1, 7, 0, 0, 1, 1),      O_LU});
        vecs.push_back('{"lu_r0",         mk(0, 1, 0, 0, 0, 0, 0, 1, 1),      O_DEF});
        vecs.push_back('{"no_memread",    mk(0, 0, 3, 3, 3, 0, 0, 1, 1),      O_DEF});
        vecs.push_back('{"br_over_lu",    mk(0, 1, 2, 2, 0, 1, 0, 1, 1),      O_BR});
        vecs.push_back('{"imem_miss",     mk(0, 0, 0, 0, 0, 0, 0, 1, 0),      O_IF});
        vecs.push_back('{"lu_imem_miss",  mk(0, 1, 9, 4, 9, 0, 0, 1, 0),      O_LU});
        vecs.push_back('{"br_imem_miss",  mk(0, 0, 0, 0, 0, 1, 0, 1, 0),      O_BR});
        vecs.push_back('{"mem_zero_wait", mk(0, 0, 0, 0, 0, 0, 1, 1, 1),      O_MOK});
        vecs.push_back('{"mem_over_br",   mk(0, 1, 2, 2, 0, 1, 1, 1, 1),      O_MOK});

        // Reset values while reset is held
        cur = rst_in;
        #3;
        chk("reset_outputs", 32'(o), 32'(O_HLT));
        @(posedge clk); #1;
        chk("reset_counters", {mem_error, 3'b0, stall_cycles, flush_count}, 32'd0);

        foreach (vecs[k]) step(vecs[k].name, vecs[k].i, vecs[k].exp);

        // Load-use: one stall, then the bubble removes the hazard
        step("rst", rst_in, O_HLT);
        step("lu_stall", mk(0, 1, 2, 2, 0, 0, 0, 1, 1), O_LU);
        step("lu_after", mk(0, 0, 2, 2, 0, 0, 0, 1, 1), O_DEF);
        chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);

        // Branch beats load-use
        step("rst", rst_in, O_HLT);
        step("br_lu", mk(0, 1, 2, 2, 0, 1, 0, 1, 1), O_BR);
        chk("br_flush_cnt", 32'(flush_count), 32'd1);
        chk("br_stall_cnt", 32'(stall_cycles), 32'd0);

        // Three-cycle dmem wait; request held even after MEM_mem_access drops
        step("rst", rst_in, O_HLT);
        step("dw_frz1", mk(0, 0, 0, 0, 0, 0, 1, 0, 1), O_FRZ);
        step("dw_frz2", mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_FRZ);
        step("dw_frz3", mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_FRZ);
        step("dw_release", mk(0, 0, 0, 0, 0, 0, 1, 1, 1), O_MOK);
        chk("dw_stall_cnt", 32'(stall_cycles), 32'd3);
        step("dw_back_run", idle, O_DEF);

        // Branch held in EX during the wait is acted on only at release
        step("rst", rst_in, O_HLT);
        step("bw_frz1", mk(0, 0, 0, 0, 0, 1, 1, 0, 1), O_FRZ);
        step("bw_frz2", mk(0, 0, 0, 0, 0, 1, 1, 0, 1), O_FRZ);
        chk("bw_no_flush_yet", 32'(flush_count), 32'd0);
        step("bw_release", mk(0, 0, 0, 0, 0, 1, 0, 1, 1), O_BR | O_REQ);
        chk("bw_flush_cnt", 32'(flush_count), 32'd1);
        chk("bw_stall_cnt", 32'(stall_cycles), 32'd2);

        // Timeout to HALT, then reset recovery
        step("rst", rst_in, O_HLT);
        for (int k = 0; k < TO; k++) begin
            if (k == TO - 1) chk("to_err_early", 32'(mem_error), 32'd0);
            step("to_frz", mk(0, 0, 0, 0, 0, 0, 1, 0, 1), O_FRZ);
        end
        chk("to_mem_error", 32'(mem_error), 32'd1);
        step("to_halt_out", mk(0, 0, 0, 0, 0, 1, 1, 1, 1), O_HLT);
        chk("to_halt_stall", 32'(stall_cycles), 32'(TO));
        step("to_reset_out", rst_in, O_HLT);
        chk("to_reset_clear", {mem_error, 3'b0, stall_cycles, flush_count}, 32'd0);
        step("to_run_again", idle, O_DEF);

        // Reset in the middle of a wait drops the request immediately
        step("frz_then_rst", mk(0, 0, 0, 0, 0, 0, 1, 0, 1), O_FRZ);
        step("mid_wait_reset", mk(1, 0, 0, 0, 0, 0, 1, 0, 1), O_HLT);
        step("after_reset", idle, O_DEF);

        // Counter saturation
        for (int k = 0; k < CMAX + 5; k++) step("sat_fetch", mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_IF);
        chk("stall_saturate", 32'(stall_cycles), 32'(CMAX));
        step("rst", rst_in, O_HLT);
        for (int k = 0; k < CMAX + 3; k++) step("sat_br", mk(0, 0, 0, 0, 0, 1, 0, 1, 1), O_BR);
        chk("flush_saturate", 32'(flush_count), 32'(CMAX));

        // Randomised run against the reference model
        cur = rst_in;
        @(posedge clk); #1;
        commit(7, O_HLT);
        for (int n = 0; n < 3000; n++) begin
            in_t x;
            int ev;
            logic [6:0] e;
            x.rst = ($urandom_range(0, 59) == 0);
            x.mr  = 1'($urandom_range(0, 1));
            x.ext = 5'($urandom_range(0, 3));
            x.rs  = 5'($urandom_range(0, 3));
            x.rt  = 5'($urandom_range(0, 3));
            x.br  = ($urandom_range(0, 4) == 0);
            x.ma  = ($urandom_range(0, 3) == 0);
            x.dr  = ($urandom_range(0, 2) != 0);
            x.ir  = ($urandom_range(0, 3) != 0);
            ev = classify(x);
            e  = expect_out(ev);
            cur = x;
            #3;
            chk("rand_outputs", 32'(o), 32'(e));
            @(posedge clk);
            commit(ev, e);
            #1;
            chk("rand_state", {mem_error, 3'b0, stall_cycles, flush_count},
                {m_err, 3'b0, CW'(m_stall), CW'(m_flush)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
